// File: rtl/d_sram_to_sram_like.sv
// Data-side adapter from the MEM-stage SRAM port to the SRAM-like handshake bus.
// One access is outstanding at a time; read data is held until the pipeline advances.
module d_sram_to_sram_like (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic        longest_stall,
  output logic        d_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_DATA = 2'd1;
  localparam logic [1:0] DONE      = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] rdata_save;
  logic        capture;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state, bus request, and the read-data capture strobe.
  always_comb begin
    state_next = state;
    data_req   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        data_req = data_sram_en;
        if (data_sram_en && data_addr_ok && data_data_ok) begin
          state_next = DONE;
          capture    = 1'b1;
        end else if (data_sram_en && data_addr_ok) begin
          state_next = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (data_data_ok) begin
          state_next = DONE;
          capture    = 1'b1;
        end
      end
      DONE: begin
        if (!longest_stall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stray data_ok (DONE, or IDLE without an accepted request) never reaches the capture register.
  always_ff @(posedge clk) begin
    if (!rst)         rdata_save <= 32'd0;
    else if (capture) rdata_save <= data_rdata;
  end

  assign data_sram_rdata = rdata_save;
  assign d_stall         = data_sram_en && (state != DONE);
  assign data_wr         = |data_sram_wen;
  assign data_wdata      = data_sram_wdata;

  // Reads and unsupported lane patterns go out as aligned words.
  always_comb begin
    data_size = 2'd2;
    data_addr = {data_sram_addr[31:2], 2'b00};
    case (data_sram_wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
        data_size = 2'd0;
        data_addr = data_sram_addr;
      end
      4'b0011, 4'b1100: begin
        data_size = 2'd1;
        data_addr = data_sram_addr;
      end
      4'b1111: begin
        data_size = 2'd2;
        data_addr = data_sram_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_d_sram_to_sram_like.sv
// Directed and randomized transactions for d_sram_to_sram_like, checked against a
// transaction-level model of request duration, stall window, size map and read capture.
module tb_d_sram_to_sram_like;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        longest_stall;
  logic        d_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic [31:0] exp_rdata;

  d_sram_to_sram_like dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .longest_stall   (longest_stall),
    .d_stall         (d_stall),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_rdata      (data_rdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
  task automatic drive(input logic p_en, input logic [3:0] p_wen, input logic [31:0] p_addr,
                       input logic [31:0] p_wdata, input logic [31:0] p_rd,
                       input logic p_aok, input logic p_dok, input logic p_ls);
    @(negedge clk);
    data_sram_en    = p_en;
    data_sram_wen   = p_wen;
    data_sram_addr  = p_addr;
    data_sram_wdata = p_wdata;
    data_rdata      = p_rd;
    data_addr_ok    = p_aok;
    data_data_ok    = p_dok;
    longest_stall   = p_ls;
    #1;
  endtask

  // Bus size/address the access should produce, from the lane-count rule.
  function automatic void model_map(input logic [3:0] wen, input logic [31:0] addr,
                                    output logic [1:0] size, output logic [31:0] baddr);
    size  = 2'd2;
    baddr = addr & 32'hFFFF_FFFC;
    if (wen != 4'd0) begin
      if ($countones(wen) == 1)            begin size = 2'd0; baddr = addr; end
      else if (wen == 4'd3 || wen == 4'd12) begin size = 2'd1; baddr = addr; end
      else if (wen == 4'd15)                begin size = 2'd2; baddr = addr; end
    end
  endfunction

  // One access: addr_ok after a cycles, data_ok k cycles later, then s extra stall cycles in DONE.
  task automatic run_txn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input int a, input int k, input int s,
                         input logic stray);
    logic [1:0]  esize;
    logic [31:0] eaddr;
    model_map(wen, addr, esize, eaddr);
    for (int c = 0; c <= a + k; c++) begin
      drive(1'b1, wen, addr, wdata, (c == a + k) ? rd : $urandom, c == a, c == a + k, 1'b1);
      check("req_pending", 32'(data_req), 32'(c <= a));
      check("stall_pending", 32'(d_stall), 32'd1);
      check("rdata_pending", data_sram_rdata, exp_rdata);
      if (c <= a) begin
        check("bus_addr", data_addr, eaddr);
        check("bus_size", 32'(data_size), 32'(esize));
        check("bus_wr", 32'(data_wr), 32'(wen != 4'd0));
        check("bus_wdata", data_wdata, wdata);
      end
    end
    exp_rdata = rd;
    for (int c = 0; c < s; c++) begin
      drive(1'b1, wen, addr, wdata, $urandom, 1'b0, stray, 1'b1);
      check("req_hold", 32'(data_req), 32'd0);
      check("stall_hold", 32'(d_stall), 32'd0);
      check("rdata_hold", data_sram_rdata, exp_rdata);
    end
    drive(1'b1, wen, addr, wdata, $urandom, 1'b0, 1'b0, 1'b0);
    check("req_release", 32'(data_req), 32'd0);
    check("stall_release", 32'(d_stall), 32'd0);
    check("rdata_release", data_sram_rdata, exp_rdata);
    drive(1'b0, 4'd0, $urandom, $urandom, $urandom, 1'($urandom), stray, 1'b0);
    check("req_gap", 32'(data_req), 32'd0);
    check("stall_gap", 32'(d_stall), 32'd0);
    check("rdata_gap", data_sram_rdata, exp_rdata);
  endtask

  initial begin
    logic [3:0] wen_tab [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    logic [3:0] w;

    rst = 1'b0;
    data_sram_en = 1'b0; data_sram_wen = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
    data_rdata = 32'd0; data_addr_ok = 1'b0; data_data_ok = 1'b0; longest_stall = 1'b0;
    repeat (2) @(posedge clk);
    exp_rdata = 32'd0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    check("reset_rdata", data_sram_rdata, 32'd0);
    check("reset_stall", 32'(d_stall), 32'd0);
    check("reset_req", 32'(data_req), 32'd0);

    // Single-cycle read with unaligned address.
    drive(1'b1, 4'd0, 32'h1000_0006, 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
    check("rd1_req", 32'(data_req), 32'd1);
    check("rd1_addr", data_addr, 32'h1000_0004);
    check("rd1_size", 32'(data_size), 32'd2);
    check("rd1_stall", 32'(d_stall), 32'd1);
    drive(1'b1, 4'd0, 32'h1000_0006, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("rd1_stall_n1", 32'(d_stall), 32'd0);
    check("rd1_req_n1", 32'(data_req), 32'd0);
    check("rd1_rdata", data_sram_rdata, 32'hDEAD_BEEF);
    exp_rdata = 32'hDEAD_BEEF;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Split write, delayed addr_ok, external stall hold, byte-write size map.
    run_txn(4'b0011, 32'h0000_2002, 32'h0000_1234, 32'hA5A5_0001, 0, 3, 0, 1'b0);
    run_txn(4'b0000, 32'h0000_3008, 32'd0,         32'h1357_9BDF, 2, 1, 0, 1'b0);
    run_txn(4'b0000, 32'h0000_400C, 32'd0,         32'hCAFE_F00D, 0, 0, 5, 1'b1);
    run_txn(4'b0001, 32'h0000_5001, 32'h11,        32'h0,         0, 0, 0, 1'b0);
    run_txn(4'b0100, 32'h0000_5002, 32'h2200,      32'h1,         1, 0, 0, 1'b0);
    run_txn(4'b1000, 32'h0000_5003, 32'h3300_0000, 32'h2,         0, 1, 0, 1'b0);
    run_txn(4'b1111, 32'h0000_5004, 32'h4444_4444, 32'h3,         0, 0, 1, 1'b1);
    run_txn(4'b0101, 32'h0000_5007, 32'h5555_5555, 32'h4,         0, 0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      w = wen_tab[$urandom_range(0, 7)];
      run_txn(w, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Flush: en drops while waiting for data; the access still completes through DONE.
    drive(1'b1, 4'd0, 32'h0000_6000, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    check("fl_req", 32'(data_req), 32'd1);
    drive(1'b0, 4'd0, 32'h0000_6000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("fl_wait_stall", 32'(d_stall), 32'd0);
    check("fl_wait_req", 32'(data_req), 32'd0);
    drive(1'b0, 4'd0, 32'h0000_6000, 32'd0, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0);
    check("fl_dok_stall", 32'(d_stall), 32'd0);
    drive(1'b1, 4'd0, 32'h0000_7000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("fl_done_req", 32'(data_req), 32'd0);
    check("fl_done_stall", 32'(d_stall), 32'd0);
    check("fl_rdata", data_sram_rdata, 32'h0BAD_F00D);
    drive(1'b1, 4'd0, 32'h0000_7000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("fl_done2_req", 32'(data_req), 32'd0);
    drive(1'b1, 4'd0, 32'h0000_7000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("fl_idle_req", 32'(data_req), 32'd1);
    check("fl_idle_stall", 32'(d_stall), 32'd1);

    // Reset mid-transaction, then a stray data_ok with en low.
    drive(1'b1, 4'd0, 32'h0000_7000, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    check("rs_req", 32'(data_req), 32'd1);
    drive(1'b1, 4'd0, 32'h0000_7000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("rs_wait_req", 32'(data_req), 32'd0);
    check("rs_wait_stall", 32'(d_stall), 32'd1);
    rst = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    check("rs_rdata", data_sram_rdata, 32'd0);
    check("rs_stall", 32'(d_stall), 32'd0);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'hFEED_FACE, 1'b0, 1'b1, 1'b0);
    check("rs_stray_stall", 32'(d_stall), 32'd0);
    check("rs_stray_req", 32'(data_req), 32'd0);
    drive(1'b1, 4'd0, 32'h0000_8000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("rs_after_rdata", data_sram_rdata, 32'd0);
    check("rs_after_req", 32'(data_req), 32'd1);
    check("rs_after_stall", 32'(d_stall), 32'd1);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("rs_end_req", 32'(data_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
